// File: rtl/adat_deframer_if.sv
// ADAT deframer bus: the decoded bitstream with its bit strobe, plus the
// recovered channel words, user bits and status pulses.
interface adat_deframer_if;
  logic        en;
  logic        d;
  logic [23:0] sample;
  logic [2:0]  chan;
  logic        sample_valid;
  logic [3:0]  user;
  logic        frame_done;
  logic        err;
  logic        locked;

  // Bitstream source side.
  modport master (
    output en, d,
    input  sample, chan, sample_valid, user, frame_done, err, locked
  );

  // Deframer side.
  modport slave (
    input  en, d,
    output sample, chan, sample_valid, user, frame_done, err, locked
  );
endinterface

// File: rtl/adat_deframer.sv
// ADAT frame deframer. Hunts for the sync run (>=10 zeros then a 1), then
// reads 4 user bits and 48 separator-led nibbles, presenting 8 channel words
// of 24 bits each. Separator violations abort the frame and drop lock.
// Optional feature: define ADAT_DEFRAMER_USER_EN to capture the user bits;
// otherwise they are consumed and the user output is tied to zero.
module adat_deframer (
  input  logic           clk,
  input  logic           rst_n,
  adat_deframer_if.slave bus
);

  typedef enum logic [1:0] {HUNT, USER, SEP, NIB} state_t;

  state_t      state;
  logic [3:0]  zero_cnt;
  logic [1:0]  bit_cnt;
  logic [2:0]  nib_cnt;
  logic [2:0]  chan_cnt;
  logic [23:0] shift;
`ifdef ADAT_DEFRAMER_USER_EN
  logic [3:0]  shadow;
`endif

`ifndef ADAT_DEFRAMER_USER_EN
  assign bus.user = 4'h0;
`endif

  // Frame state machine with registered outputs; advances only on bit strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= HUNT;
      zero_cnt         <= 4'd0;
      bit_cnt          <= 2'd0;
      nib_cnt          <= 3'd0;
      chan_cnt         <= 3'd0;
      shift            <= 24'd0;
      bus.sample       <= 24'd0;
      bus.chan         <= 3'd0;
      bus.sample_valid <= 1'b0;
      bus.frame_done   <= 1'b0;
      bus.err          <= 1'b0;
      bus.locked       <= 1'b0;
`ifdef ADAT_DEFRAMER_USER_EN
      shadow           <= 4'h0;
      bus.user         <= 4'h0;
`endif
    end else begin
      // NOTE: state is updated with non-blocking assignments so every branch
      // below reads the pre-edge values; the pulses default low and are only
      // raised for the single edge that produces them.
      bus.sample_valid <= 1'b0;
      bus.frame_done   <= 1'b0;
      bus.err          <= 1'b0;

      if (bus.en) begin
        unique case (state)
          HUNT: begin
            if (!bus.d) begin
              if (zero_cnt != 4'd15) zero_cnt <= zero_cnt + 4'd1;
            end else if (zero_cnt >= 4'd10) begin
              // Start bit after a long enough zero run: a new frame begins.
              state    <= USER;
              zero_cnt <= 4'd0;
              bit_cnt  <= 2'd0;
              nib_cnt  <= 3'd0;
              chan_cnt <= 3'd0;
              shift    <= 24'd0;
            end else begin
              zero_cnt <= 4'd0;
            end
          end

          USER: begin
`ifdef ADAT_DEFRAMER_USER_EN
            shadow  <= {shadow[2:0], bus.d};
`endif
            bit_cnt <= bit_cnt + 2'd1;
            if (bit_cnt == 2'd3) state <= SEP;
          end

          SEP: begin
            if (bus.d) begin
              state   <= NIB;
              bit_cnt <= 2'd0;
`ifdef ADAT_DEFRAMER_USER_EN
              // The first accepted separator commits this frame's user bits.
              if (nib_cnt == 3'd0 && chan_cnt == 3'd0) bus.user <= shadow;
`endif
            end else begin
              // Broken separator: drop the partial frame and count this zero
              // as the first of the next sync run.
              bus.err    <= 1'b1;
              bus.locked <= 1'b0;
              state      <= HUNT;
              zero_cnt   <= 4'd1;
              nib_cnt    <= 3'd0;
              chan_cnt   <= 3'd0;
            end
          end

          NIB: begin
            shift   <= {shift[22:0], bus.d};
            bit_cnt <= bit_cnt + 2'd1;
            if (bit_cnt == 2'd3) begin
              if (nib_cnt == 3'd5) begin
                bus.sample       <= {shift[22:0], bus.d};
                bus.chan         <= chan_cnt;
                bus.sample_valid <= 1'b1;
                nib_cnt          <= 3'd0;
                chan_cnt         <= chan_cnt + 3'd1;
                if (chan_cnt == 3'd7) begin
                  bus.frame_done <= 1'b1;
                  bus.locked     <= 1'b1;
                  state          <= HUNT;
                  zero_cnt       <= 4'd0;
                end else begin
                  state <= SEP;
                end
              end else begin
                nib_cnt <= nib_cnt + 3'd1;
                state   <= SEP;
              end
            end
          end

          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule
